// File: rtl/smol_alu_issue.sv
// Decode/issue/writeback engine for smolALU: accepts one RV32I OP/OP-IMM instruction,
// drives the combinational ALU for one cycle, then retires the result and writes rd back.
module smol_alu_issue #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2_or_imm,
    output logic [4:0]        alu_op_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              retire_valid,
    input  logic              retire_ready,
    output logic [4:0]        retire_rd,
    output logic [DATA_W-1:0] retire_data,
    output logic              retire_illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned IMM_W  = 12;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [REG_AW-1:0] rd_idx;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    logic              dec_legal;
    logic              dec_imm;
    logic [OP_W-1:0]   dec_op;

    logic [REG_AW-1:0] rd_q;
    logic              legal_q;

    assign opcode   = instr[6:0];
    assign rd_idx   = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1_idx  = instr[19:15];
    assign rs2_idx  = instr[24:20];
    assign funct7   = instr[31:25];
    assign imm_sext = {{(DATA_W-IMM_W){instr[31]}}, instr[31:20]};

    // x0 never gets written, but force zero so the read path does not depend on that
    assign rs1_val  = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    assign rs2_val  = (rs2_idx == '0) ? '0 : regs[rs2_idx];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    // Instruction decode to ALU function select and legality
    always_comb begin
        dec_legal = 1'b0;
        dec_imm   = 1'b0;
        dec_op    = '0;
        if (opcode == OPC_OP) begin
            if (funct7 == F7_ZERO) begin
                dec_legal = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_W'(0);
                    3'b111:  dec_op = OP_W'(2);
                    3'b110:  dec_op = OP_W'(3);
                    3'b100:  dec_op = OP_W'(4);
                    3'b101:  dec_op = OP_W'(5);
                    3'b001:  dec_op = OP_W'(6);
                    3'b011:  dec_op = OP_W'(7);
                    default: dec_legal = 1'b0;
                endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                dec_legal = 1'b1;
                dec_op    = OP_W'(1);
            end
        end else if (opcode == OPC_OP_IMM) begin
            dec_imm   = 1'b1;
            dec_legal = 1'b1;
            case (funct3)
                3'b000:  dec_op = OP_W'(0);
                3'b111:  dec_op = OP_W'(2);
                3'b110:  dec_op = OP_W'(3);
                3'b100:  dec_op = OP_W'(4);
                3'b011:  dec_op = OP_W'(7);
                3'b101: begin
                    dec_op    = OP_W'(5);
                    dec_legal = (funct7 == F7_ZERO);
                end
                3'b001: begin
                    dec_op    = OP_W'(6);
                    dec_legal = (funct7 == F7_ZERO);
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // FSM, registered ALU drive, retire registers and register file.
    // ALU operands are captured at acceptance: any retirement write has already
    // landed by then, so this matches a read during EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            instr_ready    <= 1'b1;
            alu_rs1        <= '0;
            alu_rs2_or_imm <= '0;
            alu_op_sel     <= '0;
            rd_q           <= '0;
            legal_q        <= 1'b0;
            retire_valid   <= 1'b0;
            retire_rd      <= '0;
            retire_data    <= '0;
            retire_illegal <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        state          <= EXEC;
                        instr_ready    <= 1'b0;
                        rd_q           <= rd_idx;
                        legal_q        <= dec_legal;
                        alu_rs1        <= dec_legal ? rs1_val : '0;
                        alu_rs2_or_imm <= dec_legal ? (dec_imm ? imm_sext : rs2_val) : '0;
                        alu_op_sel     <= dec_legal ? dec_op : '0;
                    end
                end
                EXEC: begin
                    state          <= WB;
                    alu_rs1        <= '0;
                    alu_rs2_or_imm <= '0;
                    alu_op_sel     <= '0;
                    retire_valid   <= 1'b1;
                    retire_rd      <= rd_q;
                    retire_data    <= legal_q ? alu_out : '0;
                    retire_illegal <= !legal_q;
                end
                WB: begin
                    if (retire_ready) begin
                        if (!retire_illegal && retire_rd != '0) begin
                            regs[retire_rd] <= retire_data;
                        end
                        state        <= IDLE;
                        instr_ready  <= 1'b1;
                        retire_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    instr_ready  <= 1'b1;
                    retire_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smol_alu_issue.sv
// Randomised self-checking bench for smol_alu_issue with a transaction-level model
// of the register file and an in-bench combinational smolALU.
module tb_smol_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2_or_imm;
    logic [4:0]  alu_op_sel;
    logic [31:0] alu_out;
    logic        retire_valid;
    logic        retire_ready;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        retire_illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    bit run     = 0;
    bit in_exec = 0;
    logic [31:0] mregs [32];

    smol_alu_issue #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_rs1(alu_rs1), .alu_rs2_or_imm(alu_rs2_or_imm), .alu_op_sel(alu_op_sel),
        .alu_out(alu_out),
        .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_rd(retire_rd),
        .retire_data(retire_data), .retire_illegal(retire_illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return a >> b[4:0];
            5'd6:    return a << b[4:0];
            5'd7:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_op_sel, alu_rs1, alu_rs2_or_imm);

    // Table of supported encodings: opcode, funct3, funct7 (if constrained), op_sel
    task automatic pat(input int i, output logic [6:0] opc, output logic [2:0] f3,
                       output logic [6:0] f7, output bit chk, output logic [4:0] op);
        opc = (i < 8) ? 7'b0110011 : 7'b0010011;
        f7  = 7'h00;
        chk = 1'b1;
        case (i)
            0:  begin f3 = 3'b000; op = 5'd0; end
            1:  begin f3 = 3'b000; op = 5'd1; f7 = 7'h20; end
            2:  begin f3 = 3'b111; op = 5'd2; end
            3:  begin f3 = 3'b110; op = 5'd3; end
            4:  begin f3 = 3'b100; op = 5'd4; end
            5:  begin f3 = 3'b101; op = 5'd5; end
            6:  begin f3 = 3'b001; op = 5'd6; end
            7:  begin f3 = 3'b011; op = 5'd7; end
            8:  begin f3 = 3'b000; op = 5'd0; chk = 1'b0; end
            9:  begin f3 = 3'b111; op = 5'd2; chk = 1'b0; end
            10: begin f3 = 3'b110; op = 5'd3; chk = 1'b0; end
            11: begin f3 = 3'b100; op = 5'd4; chk = 1'b0; end
            12: begin f3 = 3'b101; op = 5'd5; end
            13: begin f3 = 3'b001; op = 5'd6; end
            default: begin f3 = 3'b011; op = 5'd7; chk = 1'b0; end
        endcase
    endtask

    task automatic model_decode(input logic [31:0] w, output bit legal, output logic [4:0] op, output bit is_imm);
        logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; bit chk; logic [4:0] o;
        legal = 1'b0; op = 5'd0; is_imm = 1'b0;
        for (int i = 0; i < 15; i++) begin
            pat(i, opc, f3, f7, chk, o);
            if (w[6:0] == opc && w[14:12] == f3 && (!chk || w[31:25] == f7)) begin
                legal  = 1'b1;
                op     = o;
                is_imm = (opc == 7'b0010011);
            end
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle checks: debug read port against model, ALU idle outside EXEC
    always @(negedge clk) begin
        if (run && rst_n) begin
            check32("dbg_data", dbg_data, mregs[dbg_addr]);
            if (!in_exec)
                check32("alu_idle_zero", alu_rs1 | alu_rs2_or_imm | 32'(alu_op_sel), 32'd0);
        end
    end

    task automatic read_dbg(input logic [4:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // One full transaction; called just after a rising edge
    task automatic do_instr(input logic [31:0] w, input int bp, output logic [31:0] got_data);
        bit legal, is_imm; logic [4:0] op; logic [31:0] a, b, res; int waits;
        logic [4:0] rd;
        model_decode(w, legal, op, is_imm);
        rd  = w[11:7];
        a   = legal ? mregs[w[19:15]] : 32'd0;
        b   = legal ? (is_imm ? {{20{w[31]}}, w[31:20]} : mregs[w[24:20]]) : 32'd0;
        res = legal ? alu_f(op, a, b) : 32'd0;
        if (!legal) op = 5'd0;
        instr = w;
        instr_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!instr_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        check32("accept_wait_cycles", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = $urandom;
        in_exec = 1'b1;
        @(negedge clk);
        check32("exec_op_sel", 32'(alu_op_sel), 32'(op));
        check32("exec_rs1", alu_rs1, a);
        check32("exec_rs2_or_imm", alu_rs2_or_imm, b);
        check32("exec_ready_low", 32'(instr_ready), 32'd0);
        check32("exec_retire_valid_low", 32'(retire_valid), 32'd0);
        @(posedge clk);
        #1;
        in_exec = 1'b0;
        dbg_addr = rd;
        @(negedge clk);
        got_data = retire_data;
        for (int k = 0; k <= bp; k++) begin
            if (k > 0) @(negedge clk);
            check32("wb_valid", 32'(retire_valid), 32'd1);
            check32("wb_rd", 32'(retire_rd), 32'(rd));
            check32("wb_data", retire_data, res);
            check32("wb_illegal", 32'(retire_illegal), 32'(!legal));
            check32("wb_ready_low", 32'(instr_ready), 32'd0);
        end
        retire_ready = 1'b1;
        @(posedge clk);
        #1;
        retire_ready = 1'b0;
        if (legal && rd != 5'd0) mregs[rd] = res;
        dbg_addr = 5'($urandom);
    endtask

    task automatic gen_random(output logic [31:0] w);
        logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; bit chk; logic [4:0] op;
        logic [4:0] f24;
        if ($urandom_range(0, 9) == 0) begin
            w = $urandom;
        end else begin
            pat(int'($urandom_range(0, 14)), opc, f3, f7, chk, op);
            if (!chk) f7 = 7'($urandom);
            f24 = (opc == 7'b0010011) ? 5'($urandom) : 5'($urandom_range(0, 7));
            w = {f7, f24, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)), opc};
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] w;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 32'd0;
        retire_ready = 1'b0;
        dbg_addr = 5'd0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check32("reset_instr_ready", 32'(instr_ready), 32'd1);
        check32("reset_retire_valid", 32'(retire_valid), 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_dbg(5'(i), d);
            check32("reset_dbg", d, 32'd0);
        end
        @(posedge clk);
        #1;
        run = 1'b1;

        do_instr(32'hFFF00093, 0, d);
        check32("addi_x1_m1", d, 32'hFFFFFFFF);
        do_instr(32'h401001B3, 0, d);
        check32("sub_x3", d, 32'd1);
        read_dbg(5'd3, d);
        check32("dbg_x3", d, 32'd1);
        do_instr(32'h00500013, 0, d);
        check32("addi_x0_data", d, 32'd5);
        read_dbg(5'd0, d);
        check32("dbg_x0", d, 32'd0);
        do_instr(32'h12300293, 5, d);
        check32("bp_addi_x5", d, 32'h00000123);
        read_dbg(5'd5, d);
        check32("dbg_x5", d, 32'h00000123);
        do_instr(32'h02208233, 0, d);
        check32("mul_illegal_data", d, 32'd0);
        read_dbg(5'd4, d);
        check32("dbg_x4_unchanged", d, 32'd0);
        do_instr(32'h4050D093, 2, d);
        check32("srai_illegal_data", d, 32'd0);
        read_dbg(5'd1, d);
        check32("dbg_x1_unchanged", d, 32'hFFFFFFFF);

        for (int n = 0; n < 250; n++) begin
            gen_random(w);
            do_instr(w, int'($urandom_range(0, 3)), d);
        end

        // Reset while a result is waiting in WB
        instr = 32'h00700093;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        in_exec = 1'b1;
        @(posedge clk);
        #1;
        in_exec = 1'b0;
        @(negedge clk);
        check32("midrst_in_wb", 32'(retire_valid), 32'd1);
        #2;
        run = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        #1;
        check32("midrst_valid_drop", 32'(retire_valid), 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_dbg(5'(i), d);
            check32("midrst_dbg", d, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check32("midrst_ready_after", 32'(instr_ready), 32'd1);
        check32("midrst_valid_after", 32'(retire_valid), 32'd0);
        run = 1'b1;
        do_instr(32'h00900113, 1, d);
        check32("post_reset_addi", d, 32'd9);
        read_dbg(5'd1, d);
        check32("post_reset_x1", d, 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
